// File: rtl/noc_output_arbiter_if.sv
// Output-port bundle between the arbiter and its input ports / downstream link.
interface noc_output_arbiter_if #(
    parameter int unsigned NUM_IN = 5,
    parameter int unsigned DATA_W = 16,
    parameter int unsigned CNT_W  = 3
);
    logic [NUM_IN-1:0]        req_i;
    logic [NUM_IN-1:0]        tail_i;
    logic [NUM_IN*DATA_W-1:0] data_i;
    logic [NUM_IN-1:0]        gnt_o;
    logic [DATA_W-1:0]        data_o;
    logic                     send_o;
    logic                     inc_credit_i;
    logic [CNT_W-1:0]         credit_o;
    logic                     busy_o;
    logic                     err_o;

    // Requesting side: input ports plus the downstream credit return
    modport master (
        output req_i, tail_i, data_i, inc_credit_i,
        input  gnt_o, data_o, send_o, credit_o, busy_o, err_o
    );

    // Arbiter side
    modport slave (
        input  req_i, tail_i, data_i, inc_credit_i,
        output gnt_o, data_o, send_o, credit_o, busy_o, err_o
    );
endinterface

// File: rtl/noc_output_arbiter.sv
// Wormhole round-robin arbiter for one router output port with credit-based
// flow control. A packet owns the port from its head flit to its tail flit.
module noc_output_arbiter #(
    parameter int unsigned NUM_IN  = 5,
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned CREDITS = 5,
    parameter int unsigned CNT_W   = 3
) (
    input logic              clk,
    input logic              rst,
    noc_output_arbiter_if.slave bus
);
    localparam int unsigned IdxW = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;

    typedef enum logic [0:0] {StIdle, StLocked} state_e;

    state_e            state_q, state_d;
    logic [IdxW-1:0]   owner_q, owner_d;
    logic [IdxW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]  credit_q, credit_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              send_q, send_d;
    logic              err_q, err_d;

    logic              can_send;
    logic              found;
    logic [IdxW-1:0]   winner;
    logic              grant;
    logic [IdxW-1:0]   sel;
    logic [NUM_IN-1:0] gnt;

    // Only the registered count gates a send; a same-cycle return does not
    assign can_send = (credit_q != '0);

    // Round-robin search starting just after the last packet's winner
    always_comb begin
        int unsigned idx;
        found  = 1'b0;
        winner = '0;
        idx    = 0;
        for (int unsigned off = 1; off <= NUM_IN; off++) begin
            idx = (int'(rr_ptr_q) + off) % NUM_IN;
            if (!found && bus.req_i[idx]) begin
                found  = 1'b1;
                winner = IdxW'(idx);
            end
        end
    end

    // Ownership FSM: grant decision and packet lock/unlock
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        grant    = 1'b0;
        sel      = '0;
        unique case (state_q)
            StIdle: begin
                if (found && can_send) begin
                    grant = 1'b1;
                    sel   = winner;
                    if (bus.tail_i[winner]) begin
                        rr_ptr_d = winner;
                    end else begin
                        state_d = StLocked;
                        owner_d = winner;
                    end
                end
            end
            StLocked: begin
                if (bus.req_i[owner_q] && can_send) begin
                    grant = 1'b1;
                    sel   = owner_q;
                    if (bus.tail_i[owner_q]) begin
                        state_d  = StIdle;
                        rr_ptr_d = owner_q;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
        // No grant may escape while reset is held
        if (rst) begin
            grant = 1'b0;
        end
    end

    // Grant vector and the flit captured for next-cycle forwarding
    always_comb begin
        gnt = '0;
        if (grant) begin
            gnt[sel] = 1'b1;
        end
        send_d = grant;
        data_d = grant ? bus.data_i[int'(sel)*DATA_W +: DATA_W] : data_q;
    end

    // Credit counter: decrement on grant, increment on return; overflow is sticky
    always_comb begin
        credit_d = credit_q;
        err_d    = err_q;
        case ({grant, bus.inc_credit_i})
            2'b10: credit_d = credit_q - CNT_W'(1);
            2'b01: begin
                if (credit_q == CNT_W'(CREDITS)) begin
                    err_d = 1'b1;
                end else begin
                    credit_d = credit_q + CNT_W'(1);
                end
            end
            default: ;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            owner_q  <= '0;
            rr_ptr_q <= IdxW'(NUM_IN - 1);
            credit_q <= CNT_W'(CREDITS);
            data_q   <= '0;
            send_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
            credit_q <= credit_d;
            data_q   <= data_d;
            send_q   <= send_d;
            err_q    <= err_d;
        end
    end

    assign bus.gnt_o    = gnt;
    assign bus.data_o   = data_q;
    assign bus.send_o   = send_q;
    assign bus.credit_o = credit_q;
    assign bus.busy_o   = (state_q == StLocked);
    assign bus.err_o    = err_q;
endmodule
